// File: rtl/soc_bus_pkg.sv
// soc_bus_pkg: shared AHB bus definitions.
//   NUM_M_DEF       default number of bus masters
//   M_DATA/M_INSTR/M_DMA  master index constants
//   htrans_e        HTRANS encodings (IDLE, BUSY, NONSEQ, SEQ)
//   arb_state_e     arbiter FSM states (PARK, OWN, LOCK)
//   trans_allows_switch()  true when the owner's HTRANS lets the bus change hands
package soc_bus_pkg;

  localparam int NUM_M_DEF = 3;

  localparam int M_DATA  = 0;
  localparam int M_INSTR = 1;
  localparam int M_DMA   = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [1:0] {
    ST_PARK = 2'b00,
    ST_OWN  = 2'b01,
    ST_LOCK = 2'b10
  } arb_state_e;

  // A burst may only be interrupted at a transfer boundary (IDLE or the
  // first beat of a new transfer); BUSY and SEQ keep the current owner.
  function automatic logic trans_allows_switch(input logic [1:0] trans);
    return (trans == IDLE) || (trans == NONSEQ);
  endfunction

endpackage

// File: rtl/arb_pick.sv
// arb_pick: combinational winner selection.
//   req    [N-1:0]   request vector
//   start  [IW-1:0]  index where the search begins (wraps modulo N)
//   gnt_oh [N-1:0]   one-hot winner (all zero when no request)
//   valid            at least one request present
module arb_pick #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  gnt_oh,
  output logic          valid
);

  // Scan from start upward with wrap-around; the first requester found wins.
  always_comb begin
    int   idx_s;
    logic found_s;
    gnt_oh  = {N{1'b0}};
    found_s = 1'b0;
    idx_s   = 0;
    for (int i = 0; i < N; i++) begin
      idx_s = (int'(start) + i) % N;
      if (!found_s && req[idx_s]) begin
        gnt_oh[idx_s] = 1'b1;
        found_s       = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  assign valid = |req;

endmodule

// File: rtl/ahb_arbiter.sv
// ahb_arbiter: AHB bus arbiter with parking, burst protection and locked transfers.
//   hclk, hresetn   clock, asynchronous active-low reset
//   hbusreq, hlock  per-master request / locked-transfer request
//   htrans_m        per-master HTRANS, master i at [2i+1:2i]
//   hready          bus ready; nothing changes while low
//   hgrant          one-hot address-phase grant
//   hmaster         address-phase owner index
//   hmaster_d       data-phase owner index (one phase behind hmaster)
//   hmastlock       address phase is locked
// Build option: define ARB_ROUND_ROBIN_EN for round-robin arbitration;
// otherwise fixed priority with the lowest index winning.
module ahb_arbiter
  import soc_bus_pkg::*;
#(
  parameter int NUM_M = NUM_M_DEF,
  parameter int DEF_M = 0,
  localparam int MW   = (NUM_M > 1) ? $clog2(NUM_M) : 1
) (
  input  logic               hclk,
  input  logic               hresetn,
  input  logic [NUM_M-1:0]   hbusreq,
  input  logic [NUM_M-1:0]   hlock,
  input  logic [2*NUM_M-1:0] htrans_m,
  input  logic               hready,
  output logic [NUM_M-1:0]   hgrant,
  output logic [MW-1:0]      hmaster,
  output logic [MW-1:0]      hmaster_d,
  output logic               hmastlock
);

  localparam logic [MW-1:0]    DEF_IDX = MW'(DEF_M);
  localparam logic [NUM_M-1:0] DEF_OH  = {{(NUM_M-1){1'b0}}, 1'b1} << DEF_M;

  arb_state_e         state_r, state_nxt_s;
  logic [NUM_M-1:0]   hgrant_r, grant_nxt_s;
  logic [MW-1:0]      hmaster_r, master_nxt_s, hmaster_d_r;
  logic               hmastlock_r, mastlock_nxt_s;
  logic [NUM_M-1:0]   pick_oh_s;
  logic               pick_valid_s;
  logic [MW-1:0]      win_idx_s, start_s;
  logic [1:0]         owner_tr_s;
  logic               owner_lock_s, lock_ok_s, rearb_s;

`ifdef ARB_ROUND_ROBIN_EN
  logic [MW-1:0] rr_ptr_r;

  // Search begins just after the last winner so a persistent requester cannot starve others.
  always_comb begin
    start_s = (rr_ptr_r == MW'(NUM_M - 1)) ? {MW{1'b0}} : rr_ptr_r + MW'(1);
  end

  // Round-robin pointer remembers the most recent requester that won.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      rr_ptr_r <= DEF_IDX;
    end else if (rearb_s && pick_valid_s) begin
      rr_ptr_r <= win_idx_s;
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end
`else
  // Fixed priority: always search from master 0.
  always_comb begin
    start_s = {MW{1'b0}};
  end
`endif

  arb_pick #(.N(NUM_M), .IW(MW)) u_pick (
    .req    (hbusreq),
    .start  (start_s),
    .gnt_oh (pick_oh_s),
    .valid  (pick_valid_s)
  );

  // Owner's HTRANS/hlock are selected with the one-hot grant; winner index from the one-hot pick.
  always_comb begin
    owner_tr_s   = 2'b00;
    win_idx_s    = {MW{1'b0}};
    owner_lock_s = |(hlock & hgrant_r);
    for (int i = 0; i < NUM_M; i++) begin
      owner_tr_s = owner_tr_s | (htrans_m[2*i +: 2] & {2{hgrant_r[i]}});
      win_idx_s  = win_idx_s | (pick_oh_s[i] ? MW'(i) : {MW{1'b0}});
    end
  end

  // Next-state and next-output decode; everything holds unless this is a re-arbitration edge.
  always_comb begin
    state_nxt_s    = state_r;
    grant_nxt_s    = hgrant_r;
    master_nxt_s   = hmaster_r;
    mastlock_nxt_s = hmastlock_r;
    lock_ok_s      = 1'b1;
    case (state_r)
      ST_PARK: lock_ok_s = 1'b1;
      ST_OWN:  lock_ok_s = 1'b1;
      ST_LOCK: lock_ok_s = ~owner_lock_s;
      default: lock_ok_s = 1'b1;
    endcase
    rearb_s = hready & trans_allows_switch(owner_tr_s) & lock_ok_s;
    if (rearb_s) begin
      if (pick_valid_s) begin
        grant_nxt_s  = pick_oh_s;
        master_nxt_s = win_idx_s;
        if (|(hlock & pick_oh_s)) begin
          state_nxt_s    = ST_LOCK;
          mastlock_nxt_s = 1'b1;
        end else begin
          state_nxt_s    = ST_OWN;
          mastlock_nxt_s = 1'b0;
        end
      end else begin
        state_nxt_s    = ST_PARK;
        grant_nxt_s    = DEF_OH;
        master_nxt_s   = DEF_IDX;
        mastlock_nxt_s = 1'b0;
      end
    end else begin
      state_nxt_s = state_r;
    end
  end

  // FSM state register.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_r <= ST_PARK;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Registered bus outputs; data-phase owner follows address-phase owner on each ready edge.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      hgrant_r    <= DEF_OH;
      hmaster_r   <= DEF_IDX;
      hmaster_d_r <= DEF_IDX;
      hmastlock_r <= 1'b0;
    end else begin
      hgrant_r    <= grant_nxt_s;
      hmaster_r   <= master_nxt_s;
      hmastlock_r <= mastlock_nxt_s;
      if (hready) begin
        hmaster_d_r <= hmaster_r;
      end else begin
        hmaster_d_r <= hmaster_d_r;
      end
    end
  end

  assign hgrant    = hgrant_r;
  assign hmaster   = hmaster_r;
  assign hmaster_d = hmaster_d_r;
  assign hmastlock = hmastlock_r;

endmodule

// File: tb/tb_ahb_arbiter.sv
// tb_ahb_arbiter: randomized + directed scoreboard bench for ahb_arbiter (3 masters, park on 0).
// Each driven cycle pushes the reference model's expected post-edge outputs; a monitor
// pops and compares them 1 time unit after every rising edge.
module tb_ahb_arbiter;

  localparam int N  = 3;
  localparam int MW = 2;
  localparam int DEF = 0;

  logic           hclk = 1'b0;
  logic           hresetn;
  logic [N-1:0]   hbusreq, hlock;
  logic [2*N-1:0] htrans_m;
  logic           hready;
  logic [N-1:0]   hgrant;
  logic [MW-1:0]  hmaster, hmaster_d;
  logic           hmastlock;

  ahb_arbiter #(.NUM_M(N), .DEF_M(DEF)) dut (
    .hclk      (hclk),
    .hresetn   (hresetn),
    .hbusreq   (hbusreq),
    .hlock     (hlock),
    .htrans_m  (htrans_m),
    .hready    (hready),
    .hgrant    (hgrant),
    .hmaster   (hmaster),
    .hmaster_d (hmaster_d),
    .hmastlock (hmastlock)
  );

  always #5 hclk = ~hclk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [N-1:0]  g;
    logic [MW-1:0] m;
    logic [MW-1:0] md;
    logic          ml;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: who owns the bus, who owned it last phase, lock flag, last requester winner.
  int owner, owner_d, last_win;
  bit locked;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic model_reset();
    owner    = DEF;
    owner_d  = DEF;
    last_win = DEF;
    locked   = 1'b0;
  endtask

  // Apply the arbitration rules for one rising edge with the given inputs.
  task automatic model_edge(input logic [N-1:0] req, input logic [N-1:0] lk,
                            input logic [2*N-1:0] tr, input logic rdy);
    int  otr, win;
    bit  may_switch;
    if (rdy) begin
      otr        = int'((tr >> (2 * owner)) & 6'd3);
      may_switch = (otr == 0 || otr == 2) && !(locked && lk[owner]);
      owner_d    = owner;
      if (may_switch) begin
        if (req == '0) begin
          owner  = DEF;
          locked = 1'b0;
        end else begin
          win = -1;
`ifdef ARB_ROUND_ROBIN_EN
          for (int k = 1; k <= N; k++) begin
            if (win < 0 && req[(last_win + k) % N]) win = (last_win + k) % N;
          end
`else
          for (int k = 0; k < N; k++) begin
            if (win < 0 && req[k]) win = k;
          end
`endif
          owner    = win;
          locked   = lk[win];
          last_win = win;
        end
      end
    end
  endtask

  // Drive one cycle's inputs (called at posedge+2), record the expectation, and
  // return at the next posedge+2 so the caller sees the resulting outputs.
  task automatic step(input logic [N-1:0] req, input logic [N-1:0] lk,
                      input logic [2*N-1:0] tr, input logic rdy);
    exp_t e;
    hbusreq  = req;
    hlock    = lk;
    htrans_m = tr;
    hready   = rdy;
    model_edge(req, lk, tr, rdy);
    e.g  = N'(1) << owner;
    e.m  = MW'(owner);
    e.md = MW'(owner_d);
    e.ml = locked;
    exp_q.push_back(e);
    @(posedge hclk);
    #2;
  endtask

  // Scoreboard monitor.
  initial begin
    exp_t e;
    forever begin
      @(posedge hclk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb_hgrant",    32'(hgrant),    32'(e.g));
        check("sb_hmaster",   32'(hmaster),   32'(e.m));
        check("sb_hmaster_d", 32'(hmaster_d), 32'(e.md));
        check("sb_hmastlock", 32'(hmastlock), 32'(e.ml));
        check("sb_onehot",    32'($onehot(hgrant)), 32'd1);
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_hgrant"},    32'(hgrant),    32'h1);
    check({tag, "_hmaster"},   32'(hmaster),   32'h0);
    check({tag, "_hmaster_d"}, 32'(hmaster_d), 32'h0);
    check({tag, "_hmastlock"}, 32'(hmastlock), 32'h0);
  endtask

  // htrans helpers: master 0 / 1 / 2 field placement
  function automatic logic [5:0] tr_of(input logic [1:0] t0, input logic [1:0] t1, input logic [1:0] t2);
    return {t2, t1, t0};
  endfunction

  initial begin
    logic [N-1:0]   r_req, r_lk;
    logic [2*N-1:0] r_tr;
    logic           r_rdy;

    hresetn  = 1'b0;
    hbusreq  = '0;
    hlock    = '0;
    htrans_m = '0;
    hready   = 1'b1;
    model_reset();
    repeat (2) @(posedge hclk);
    #1;
    check_reset_vals("rst_hold");
    @(posedge hclk);
    #2;
    hresetn = 1'b1;

    // Reset released, no requests: stays parked on master 0.
    step(3'b000, 3'b000, tr_of(2'b00, 2'b00, 2'b00), 1'b1);
    check_reset_vals("park_idle");

    // Grant master 1 alone, then masters 1 and 2 together.
    step(3'b010, 3'b000, tr_of(2'b00, 2'b00, 2'b00), 1'b1);
    check("first_grant_m1", 32'(hgrant), 32'h2);
    step(3'b110, 3'b000, tr_of(2'b00, 2'b00, 2'b00), 1'b1);
`ifdef ARB_ROUND_ROBIN_EN
    check("req110_rr", 32'(hgrant), 32'h4);
`else
    check("req110_fixed", 32'(hgrant), 32'h2);
`endif

    // Move ownership to master 2, then an INCR4 burst with master 0 joining at beat 2.
    step(3'b100, 3'b000, tr_of(2'b00, 2'b00, 2'b00), 1'b1);
    check("own_m2", 32'(hgrant), 32'h4);
    step(3'b100, 3'b000, tr_of(2'b00, 2'b00, 2'b10), 1'b1);
    check("burst_nonseq", 32'(hgrant), 32'h4);
    for (int b = 0; b < 3; b++) begin
      step(3'b101, 3'b000, tr_of(2'b00, 2'b00, 2'b11), 1'b1);
      check("burst_seq_hold", 32'(hgrant), 32'h4);
    end
    step(3'b101, 3'b000, tr_of(2'b00, 2'b00, 2'b00), 1'b1);
    check("burst_end_m0", 32'(hgrant), 32'h1);
    check("burst_end_hmd", 32'(hmaster_d), 32'h2);

    // hready low for 3 cycles while master 1 asks for the bus.
    for (int w = 0; w < 3; w++) begin
      step(3'b010, 3'b000, tr_of(2'b00, 2'b00, 2'b00), 1'b0);
      check("wait_hgrant", 32'(hgrant), 32'h1);
      check("wait_hmaster", 32'(hmaster), 32'h0);
      check("wait_hmaster_d", 32'(hmaster_d), 32'h2);
    end
    step(3'b010, 3'b000, tr_of(2'b00, 2'b00, 2'b00), 1'b1);
    check("ready_hgrant", 32'(hgrant), 32'h2);
    check("ready_hmaster", 32'(hmaster), 32'h1);
    check("ready_hmaster_d", 32'(hmaster_d), 32'h0);
    step(3'b010, 3'b000, tr_of(2'b00, 2'b00, 2'b00), 1'b1);
    check("lag_hmaster_d", 32'(hmaster_d), 32'h1);

    // Locked sequence for master 1 while master 0 requests.
    step(3'b010, 3'b010, tr_of(2'b00, 2'b00, 2'b00), 1'b1);
    check("lock_enter", 32'(hmastlock), 32'h1);
    for (int t = 0; t < 2; t++) begin
      step(3'b011, 3'b010, tr_of(2'b00, 2'b10, 2'b00), 1'b1);
      check("lock_hold_grant", 32'(hgrant), 32'h2);
      check("lock_hold_ml", 32'(hmastlock), 32'h1);
    end
    step(3'b011, 3'b000, tr_of(2'b00, 2'b00, 2'b00), 1'b1);
    check("lock_release_grant", 32'(hgrant), 32'h1);
    check("lock_release_ml", 32'(hmastlock), 32'h0);

    // Master 2 burst interrupted by an asynchronous reset pulse.
    step(3'b100, 3'b000, tr_of(2'b00, 2'b00, 2'b00), 1'b1);
    step(3'b100, 3'b000, tr_of(2'b00, 2'b00, 2'b10), 1'b1);
    step(3'b100, 3'b000, tr_of(2'b00, 2'b00, 2'b11), 1'b1);
    check("pre_reset_m2", 32'(hgrant), 32'h4);
    hresetn = 1'b0;
    #1;
    check_reset_vals("async_rst");
    model_reset();
    @(posedge hclk);
    #2;
    check_reset_vals("rst_mid_burst_hold");
    hresetn = 1'b1;
    step(3'b000, 3'b000, tr_of(2'b00, 2'b00, 2'b11), 1'b1);
    check("no_resume_m0", 32'(hgrant), 32'h1);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 500; n++) begin
      r_req = 3'($urandom_range(0, 7));
      r_lk  = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      r_tr  = 6'($urandom);
      r_rdy = ($urandom_range(0, 3) != 0);
      step(r_req, r_lk, r_tr, r_rdy);
    end

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ahb_arbiter.md
AHB_ARBITER -- requirements
Module: ahb_arbiter

Interface
REQ-001 Parameter NUM_M, default 3: number of bus masters (0 = core data, 1 = core instr, 2 = DMA); supported range 2..4.
REQ-002 Parameter DEF_M, default 0: park (default) master index.
REQ-003 hclk  input  1  bus clock; all state updates on its rising edge.
REQ-004 hresetn  input  1  reset, asynchronous, active-low.
REQ-005 hbusreq  input  NUM_M  per-master bus request.
REQ-006 hlock  input  NUM_M  per-master locked-transfer request.
REQ-007 htrans_m  input  2*NUM_M  per-master HTRANS, master i at bits [2i+1:2i].
REQ-008 hready  input  1  bus ready from the slave-side decoder mux.
REQ-009 hgrant  output  NUM_M  one-hot address-phase grant.
REQ-010 hmaster  output  $clog2(NUM_M)  index of the address-phase owner.
REQ-011 hmaster_d  output  $clog2(NUM_M)  index of the data-phase owner, for the read-data/response return mux.
REQ-012 hmastlock  output  1  current address phase is locked.

Function
REQ-013 FSM states: PARK (no request, DEF_M granted), OWN (requester granted), LOCK (owner holds hlock).
REQ-014 No state, grant, hmaster, hmaster_d or hmastlock change while hready=0.
REQ-015 Re-arbitration only on an edge with hready=1 where the owner's htrans is IDLE (00) or NONSEQ (10) and the FSM is not in LOCK.
REQ-016 On a re-arbitration edge with no hbusreq bit set: FSM -> PARK, hgrant = one-hot(DEF_M).
REQ-017 On a re-arbitration edge with requests: FSM -> OWN (LOCK if the winner's hlock=1), winner chosen per REQ-027.
REQ-018 Owner htrans SEQ (11) or BUSY (01): grant held regardless of other requests (no mid-burst switch).
REQ-019 LOCK held while the owner's hlock=1; exits on the first hready=1 edge with owner hlock=0 and htrans IDLE/NONSEQ, then re-arbitrates that same edge.
REQ-020 hgrant, hmaster, hmastlock are registered and change only on a re-arbitration edge; latency from hbusreq rise to hgrant is one cycle when the bus is idle.
REQ-021 hmaster_d <= hmaster on every edge with hready=1 (one-phase delay).
REQ-022 hmastlock = 1 exactly while the FSM is in LOCK.
REQ-023 An owner keeping hbusreq=1 while other masters also request loses the grant at the next re-arbitration edge when round-robin is enabled; under fixed priority it keeps the grant only if it is the highest-priority requester.
REQ-024 hgrant is always exactly one-hot; never zero, never multi-hot.

Reset
REQ-025 During hresetn=0: FSM=PARK, hgrant=one-hot(DEF_M), hmaster=hmaster_d=DEF_M, hmastlock=0, RR pointer=DEF_M.
REQ-026 Reset mid-burst or mid-lock aborts immediately to the reset values; no burst resumption.

Configuration
REQ-027 Macro ARB_ROUND_ROBIN_EN defined: round-robin, search starts at (last winner+1) mod NUM_M, pointer updated on each grant to a requester; undefined: fixed priority, lowest index wins, no pointer register.

Structure
REQ-028 NUM_M default, master index constants (M_DATA, M_INSTR, M_DMA) and the HTRANS encodings (IDLE, BUSY, NONSEQ, SEQ) go in shared package soc_bus_pkg.
REQ-029 Winner selection goes in combinational sub-module arb_pick (inputs: request vector, start pointer; output: one-hot winner plus valid).

Verification
REQ-030 Reset released, no requests -> hgrant=001, hmaster=0, hmastlock=0.
REQ-031 hbusreq=110 same cycle, hready=1, fixed priority -> next edge hgrant=010; RR with pointer at 1 -> hgrant=100.
REQ-032 Master 2 INCR4 burst (NONSEQ, SEQ x3), master 0 requests at beat 2 -> hgrant stays 100 until the edge after the last SEQ, then 001.
REQ-033 hready=0 for 3 cycles during a grant change request -> hgrant, hmaster, hmaster_d frozen; update on the first hready=1 edge; hmaster_d lags hmaster by one phase.
REQ-034 Master 1 with hlock=1 for 2 transfers while master 0 requests -> hmastlock=1, hgrant=010 throughout, released the edge after hlock falls.
REQ-035 hresetn pulsed low mid-burst of master 2 -> outputs asynchronously to the reset values of REQ-025.
